// File: rtl/multiword_adder.sv
// Word-serial wide adder: streams one 32-bit word pair per cycle, LSW first,
// through a single carry-lookahead adder and registers the carry between words.

module ahead_adder32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [31:0] w_p;
    logic [31:0] w_g;
    logic [31:0] w_c;
    logic [7:0]  w_grp_p;
    logic [7:0]  w_grp_g;
    logic [8:0]  w_gc;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Full lookahead inside each 4-bit group; group carries ripple across groups.
    for (genvar j = 0; j < 8; j++) begin : g_grp
        logic [3:0] w_gp;
        logic [3:0] w_gg;
        assign w_gp = w_p[4*j +: 4];
        assign w_gg = w_g[4*j +: 4];

        assign w_grp_p[j] = &w_gp;
        assign w_grp_g[j] = w_gg[3]
                          | (w_gp[3] & w_gg[2])
                          | (w_gp[3] & w_gp[2] & w_gg[1])
                          | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0]);

        assign w_c[4*j]   = w_gc[j];
        assign w_c[4*j+1] = w_gg[0] | (w_gp[0] & w_gc[j]);
        assign w_c[4*j+2] = w_gg[1] | (w_gp[1] & w_gg[0])
                          | (w_gp[1] & w_gp[0] & w_gc[j]);
        assign w_c[4*j+3] = w_gg[2] | (w_gp[2] & w_gg[1])
                          | (w_gp[2] & w_gp[1] & w_gg[0])
                          | (w_gp[2] & w_gp[1] & w_gp[0] & w_gc[j]);
    end

    always_comb begin
        w_gc    = '0;
        w_gc[0] = i_cin;
        for (int j = 0; j < 8; j++) begin
            w_gc[j+1] = w_grp_g[j] | (w_grp_p[j] & w_gc[j]);
        end
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[8];
endmodule

module multiword_adder #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [32*WORDS-1:0]  A,
    input  logic [32*WORDS-1:0]  B,
    input  logic                 C_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [32*WORDS-1:0]  Result,
    output logic                 C_out,
    output logic                 busy
);
    localparam int W     = 32 * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_result;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;

    logic [31:0]      w_sum;
    logic             w_carry;
    logic             w_accept;
    logic             w_run;
    logic             w_last;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_idx == LAST);

    // Operands shift down each RUN cycle, so the current word is always at the bottom.
    ahead_adder32 u_add (
        .i_a    (r_a[31:0]),
        .i_b    (r_b[31:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= C_in;
            r_idx   <= '0;
            r_cout  <= 1'b0;
        end else if (w_run) begin
            r_a                           <= r_a >> 32;
            r_b                           <= r_b >> 32;
            r_result[{r_idx, 5'b0} +: 32] <= w_sum;
            r_carry                       <= w_carry;
            if (w_last) r_cout <= w_carry;
            else        r_idx  <= r_idx + 1'b1;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign Result    = r_result;
    assign C_out     = r_cout;
endmodule

// File: tb/tb_multiword_adder.sv
// Bench for multiword_adder: directed corner cases plus a randomized run
// checked against plain wide-integer addition.

module tb_multiword_adder;
    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;
    localparam int W2    = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid = 1'b0, in_ready, c_in = 1'b0, out_valid, out_ready = 1'b0, c_out, busy;
    logic [W-1:0]  a = '0, b = '0, result;
    logic          in_valid2 = 1'b0, in_ready2, c_in2 = 1'b0, out_valid2, out_ready2 = 1'b1, c_out2, busy2;
    logic [W2-1:0] a2 = '0, b2 = '0, result2;

    int errors = 0;
    int checks = 0;

    multiword_adder #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .C_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .Result(result), .C_out(c_out), .busy(busy)
    );

    multiword_adder #(.WORDS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(a2), .B(b2), .C_in(c_in2), .out_valid(out_valid2), .out_ready(out_ready2),
        .Result(result2), .C_out(c_out2), .busy(busy2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x; b = y; c_in = c; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({out_valid, in_ready, busy, c_out} !== 4'b0100) begin
            errors++; $display("FAIL reset_flags got ov/ir/busy/cout=%b want 0100", {out_valid, in_ready, busy, c_out});
        end
        checks++;
        if (result !== '0 || result2 !== '0) begin
            errors++; $display("FAIL reset_result got %h / %h want 0", result, result2);
        end
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_ready got ir=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_ripple;
        int lat;
        out_ready = 1'b1;
        start_op({W{1'b1}}, 1, 1'b0);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL ripple_busy got busy=%b ir=%b want 1 0", busy, in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat !== WORDS) begin
            errors++; $display("FAIL ripple_latency got %0d want %0d", lat, WORDS);
        end
        checks++;
        if (result !== '0 || c_out !== 1'b1) begin
            errors++; $display("FAIL ripple_sum got cout=%b res=%h want 1 0", c_out, result);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL ripple_valid_pulse got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_word_boundary;
        int lat;
        logic [W-1:0] exp;
        exp = '0;
        exp[32] = 1'b1;
        start_op(128'hFFFF_FFFF, 0, 1'b1);
        wait_valid(lat);
        checks++;
        if (result !== exp || c_out !== 1'b0) begin
            errors++; $display("FAIL boundary_carry got cout=%b res=%h want 0 %h", c_out, result, exp);
        end
        tick();
    endtask

    task automatic test_backpressure;
        int lat;
        logic [W:0] exp;
        logic [W-1:0] x, y;
        logic c;
        x = rand_w(); y = rand_w(); c = 1'($urandom);
        exp = ref_sum(x, y, c);
        out_ready = 1'b0;
        start_op(x, y, c);
        wait_valid(lat);
        checks++;
        if ({c_out, result} !== exp) begin
            errors++; $display("FAIL bp_sum got %h want %h", {c_out, result}, exp);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = rand_w(); b = rand_w(); c_in = 1'($urandom);
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || {c_out, result} !== exp) begin
                errors++;
                $display("FAIL bp_hold[%0d] got ov=%b ir=%b busy=%b sum=%h want 1 0 1 %h",
                         i, out_valid, in_ready, busy, {c_out, result}, exp);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got ir=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat;
        out_ready = 1'b1;
        start_op(rand_w(), rand_w(), 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, busy, c_out} !== 4'b0100 || result !== '0) begin
            errors++;
            $display("FAIL midrun_reset got ov/ir/busy/cout=%b res=%h want 0100 0",
                     {out_valid, in_ready, busy, c_out}, result);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_op(5, 7, 1'b0);
        wait_valid(lat);
        checks++;
        if (result !== 12 || c_out !== 1'b0 || lat !== WORDS) begin
            errors++; $display("FAIL after_reset_op got res=%0d cout=%b lat=%0d want 12 0 %0d", result, c_out, lat, WORDS);
        end
        tick();
    endtask

    task automatic test_random;
        logic [W:0] exp_q[$];
        logic [W:0] exp;
        int accepts = 0;
        int cyc = 0;
        int last_acc = -1;
        logic acc_now;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = rand_w(); b = rand_w(); c_in = 1'($urandom);
        while ((accepts < 1000 || exp_q.size() != 0) && cyc < 7000) begin
            acc_now = in_ready && in_valid;
            if (acc_now) begin
                exp_q.push_back(ref_sum(a, b, c_in));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== WORDS + 2) begin
                        errors++; $display("FAIL rand_spacing got %0d want %0d", cyc - last_acc, WORDS + 2);
                    end
                end
                last_acc = cyc;
                accepts++;
            end
            tick();
            cyc++;
            if (accepts >= 1000) in_valid = 1'b0;
            a = rand_w(); b = rand_w(); c_in = 1'($urandom);
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected got out_valid=1 want no pending op");
                end else begin
                    exp = exp_q.pop_front();
                    if ({c_out, result} !== exp) begin
                        errors++; $display("FAIL rand_sum got %h want %h", {c_out, result}, exp);
                    end
                end
            end
        end
        checks++;
        if (accepts != 1000 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_timeout got accepts=%0d pending=%0d want 1000 0", accepts, exp_q.size());
        end
    endtask

    task automatic test_words2;
        int lat;
        logic [W2-1:0] x, y;
        logic [W2:0] exp;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                x = 64'h8000_0000_0000_0000; y = 64'h8000_0000_0000_0000;
            end else begin
                x = {$urandom, $urandom}; y = {$urandom, $urandom};
            end
            exp = {1'b0, x} + {1'b0, y};
            a2 = x; b2 = y; c_in2 = 1'b0; in_valid2 = 1'b1;
            tick();
            in_valid2 = 1'b0;
            lat = 0;
            while (!out_valid2 && lat < 30) begin
                tick();
                lat++;
            end
            checks++;
            if ({c_out2, result2} !== exp || lat !== 2) begin
                errors++; $display("FAIL words2[%0d] got sum=%h lat=%0d want %h 2", t, {c_out2, result2}, lat, exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_word_boundary();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_words2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multiword_adder.md
# multiword_adder

Word-serial wide adder that sits upstream of `ahead_adder32` and drives it. It accepts two `32*WORDS`-bit operands plus a carry-in through a valid/ready handshake. It then feeds one 32-bit word pair per cycle, least-significant word first, into an internal `ahead_adder32` instance and carries `C_out` forward between cycles in a register. The assembled `32*WORDS`-bit result and final carry are presented through an output valid/ready handshake, giving wide additions at single-adder area.

## Interface

Parameters:
- `WORDS`, default 4: number of 32-bit words per operand; legal range 2..16. Operand width `W = 32*WORDS`.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands and `C_in` valid.
- `in_ready`  output  1  block can accept an operation.
- `A`  input  W  operand A.
- `B`  input  W  operand B.
- `C_in`  input  1  carry into word 0.
- `out_valid`  output  1  `Result` and `C_out` valid.
- `out_ready`  input  1  consumer accepts the result.
- `Result`  output  W  `(A + B + C_in) mod 2^W`.
- `C_out`  output  1  bit W of `A + B + C_in`.
- `busy`  output  1  high in RUN or DONE.

## Operation

- One clock domain and one reset: `clk`, with `rst_n` asynchronous and active-low.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid && in_ready` at a rising edge, register `A` and `B` into operand shift registers and set `carry<=C_in`, `idx<=0`, `C_out<=0`.
  - Move to RUN.
  - `Result` retains the previous value until overwritten word by word.
- RUN, one word per cycle:
  - `{c, s} = A_reg[idx] + B_reg[idx] + carry`, computed by the `ahead_adder32` instance.
  - At the edge, `Result[32*idx +: 32] <= s`, `carry <= c`, `idx <= idx+1`.
  - When `idx == WORDS-1`: `C_out <= c`, move to DONE.
  - `in_ready=0`. `in_valid` is ignored and operands are not re-sampled.
- DONE:
  - `out_valid=1`. `Result` and `C_out` are held stable.
  - On `out_ready` at an edge, move to IDLE and drop `out_valid`.
  - `in_ready=0`; there is no same-cycle turnaround.
- Arithmetic:
  - Unsigned.
  - `idx` is `$clog2(WORDS)` bits wide and never exceeds `WORDS-1`.
  - The carry register is the only inter-word state.
- `in_ready` and `out_valid` are decoded from the registered state only. There is no combinational path from `in_valid` or `out_ready` to either.
- Reset, at any time including mid-RUN or mid-DONE:
  - State goes to IDLE and the in-flight operation is discarded.
  - Reset values: `out_valid=0`, `in_ready=1`, `busy=0`, `Result=0`, `C_out=0`, `carry=0`, `idx=0`, operand registers 0.

## Timing

- Accept edge is E0, where `in_valid && in_ready` is sampled.
- RUN occupies edges E0+1 .. E0+WORDS. Word k is written at edge E0+1+k.
- `out_valid` rises after edge E0+WORDS, i.e. WORDS cycles of latency from accept to valid.
- Result accepted at edge Ed (`out_valid && out_ready`): `in_ready` is high from Ed onward, and the next accept can occur at Ed+1.
- Peak throughput is one operation per WORDS+2 cycles, with `in_valid` and `out_ready` held high.
- `out_ready` may be high before `out_valid`; this has no effect outside DONE.
- `in_ready` is 1 in the cycle immediately after `rst_n` deasserts.

## Test plan

1. Full-width carry ripple. `WORDS=4`, `A=128'hFFFF..FF`, `B=1`, `C_in=0`, `out_ready=1`:
   - `Result=0`, `C_out=1`.
   - `out_valid` rises exactly 4 cycles after the accept edge and lasts 1 cycle.
2. Carry-in crossing a word boundary. `A=128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF`, `B=0`, `C_in=1`:
   - `Result=128'h0000_0000_0000_0000_0000_0001_0000_0000`, `C_out=0`.
3. Backpressure. Hold `out_ready=0` for 10 cycles after `out_valid` while toggling `in_valid` and changing `A`/`B`:
   - `out_valid`, `Result` and `C_out` stay constant.
   - `in_ready` stays 0 and no new operation starts.
   - Releasing `out_ready` yields `in_ready=1` on the next cycle.
4. Reset mid-operation. Pulse `rst_n` low during the second RUN cycle:
   - All outputs read 0 and `in_ready=1` while in reset.
   - After release, `A=5`, `B=7`, `C_in=0` gives `Result=12`, `C_out=0`.
5. Randomised checking against a golden model. 1000 random `A`, `B`, `C_in` with `in_valid=1` and `out_ready=1` held high:
   - Each `{C_out, Result}` equals the 129-bit reference `A+B+C_in`.
   - Accepts are spaced exactly 6 cycles apart.
6. Parameter variant. `WORDS=2`, `A=64'h8000_0000_0000_0000`, `B=64'h8000_0000_0000_0000`:
   - `Result=0`, `C_out=1`, latency 2 cycles.
